// File: rtl/axi_llc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_pkg
// Description : Shared LLC types. It holds the descriptor record carried
//               between the splitters, the merger and the hit/miss stage. It
//               also holds the state encoding of the descriptor merger.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_llc_pkg;

  // LLC descriptor. Only x_last is interpreted by the merger; everything
  // else is forwarded untouched.
  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  id;
    logic        x_last;
  } llc_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } desc_merge_state_e;

  // Round-robin pointer encoding
  localparam logic c_RR_AW = 1'b0;
  localparam logic c_RR_AR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi_llc_desc_buf.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_desc_buf
// Description : 2-entry circular FIFO of LLC descriptors used as the merger
//               output register stage.
// Ports       : clk_i, rst_i      - clock, sync active-high reset
//               push_i, push_data_i - write strobe and data
//               pop_i             - head consumed (ignored when empty)
//               head_o            - oldest entry
//               count_o           - number of valid entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_desc_buf #(
  parameter type desc_t = axi_llc_pkg::llc_desc_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  desc_t      push_data_i,
  input  logic       pop_i,
  output desc_t      head_o,
  output logic [1:0] count_o
);

  desc_t      r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // A pop in the same cycle frees a slot, so a full buffer still takes a push.
  assign w_pop  = pop_i && (r_count != 2'd0);
  assign w_push = push_i && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; count qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end

  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/axi_llc_desc_merger.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_desc_merger
// Description : Merges AW/AR splitter descriptors (round-robin) and flush
//               descriptors (exclusive window after the splitters drain) into
//               one registered descriptor stream.
// Ports       : clk_i, rst_i                 - clock, sync active-high reset
//               aw_desc_*                    - write-splitter descriptors
//               ar_desc_*                    - read-splitter descriptors
//               aw/ar_unit_busy_i            - splitter mid-burst flags
//               flush_desc_*                 - flush descriptors (x_last ends)
//               ax_block_o                   - holds off new AW/AR vectors
//               desc_o, desc_valid_o, desc_ready_i - merged output
// Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_desc_merger
  import axi_llc_pkg::*;
#(
  parameter type desc_t = axi_llc_pkg::llc_desc_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  desc_t aw_desc_i,
  input  logic  aw_desc_valid_i,
  output logic  aw_desc_ready_o,
  input  desc_t ar_desc_i,
  input  logic  ar_desc_valid_i,
  output logic  ar_desc_ready_o,
  input  logic  aw_unit_busy_i,
  input  logic  ar_unit_busy_i,
  input  desc_t flush_desc_i,
  input  logic  flush_desc_valid_i,
  output logic  flush_desc_ready_o,
  output logic  ax_block_o,
  output desc_t desc_o,
  output logic  desc_valid_o,
  input  logic  desc_ready_i
);

  desc_merge_state_e r_state;
  desc_merge_state_e w_state_nxt;
  logic              r_rr;
  logic              r_ax_block;
  logic [1:0]        w_count;
  logic              w_space;
  logic              w_arb_en;
  logic              w_grant_aw;
  logic              w_grant_ar;
  logic              w_aw_hs;
  logic              w_ar_hs;
  logic              w_fl_hs;
  logic              w_push;
  desc_t             w_push_data;

  // Space depends on the registered fill level only, which keeps
  // desc_ready_i out of every upstream ready.
  assign w_space  = (w_count < 2'd2);
  assign w_arb_en = (r_state != ST_FLUSH);

  // One-sided requests win outright; contention follows the rr pointer.
  assign w_grant_aw = w_arb_en && aw_desc_valid_i && (!ar_desc_valid_i || (r_rr == c_RR_AW));
  assign w_grant_ar = w_arb_en && ar_desc_valid_i && (!aw_desc_valid_i || (r_rr == c_RR_AR));

  assign aw_desc_ready_o    = w_space && w_grant_aw;
  assign ar_desc_ready_o    = w_space && w_grant_ar;
  assign flush_desc_ready_o = w_space && (r_state == ST_FLUSH);

  assign w_aw_hs = aw_desc_valid_i && aw_desc_ready_o;
  assign w_ar_hs = ar_desc_valid_i && ar_desc_ready_o;
  assign w_fl_hs = flush_desc_valid_i && flush_desc_ready_o;
  assign w_push  = w_aw_hs || w_ar_hs || w_fl_hs;

  always_comb begin
    w_push_data = aw_desc_i;
    if (w_ar_hs)      w_push_data = ar_desc_i;
    else if (w_fl_hs) w_push_data = flush_desc_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_rr       <= c_RR_AW;
      r_ax_block <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ax_block <= (w_state_nxt != ST_IDLE);
      if (w_aw_hs)      r_rr <= c_RR_AR;
      else if (w_ar_hs) r_rr <= c_RR_AW;
    end
  end

  // DRAIN lasts at least one cycle, so any AW/AR descriptor granted in the
  // IDLE cycle that saw the flush request is already in the buffer before
  // FLUSH opens.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (flush_desc_valid_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!aw_unit_busy_i && !ar_unit_busy_i && !aw_desc_valid_i && !ar_desc_valid_i)
          w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_fl_hs && flush_desc_i.x_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ax_block_o = r_ax_block;

  axi_llc_desc_buf #(
    .desc_t (desc_t)
  ) u_desc_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (desc_ready_i),
    .head_o      (desc_o),
    .count_o     (w_count)
  );

  assign desc_valid_o = (w_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_desc_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_llc_desc_merger
// Description : Self-checking bench for axi_llc_desc_merger. It covers
//               arbitration and back-pressure vectors, flush/drain sequences
//               and reset while in FLUSH.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_llc_desc_merger;
  import axi_llc_pkg::*;

  logic      clk;
  logic      rst;
  llc_desc_t aw_desc, ar_desc, fl_desc, desc_out;
  logic      aw_v, aw_rdy, ar_v, ar_rdy;
  logic      aw_busy, ar_busy;
  logic      fl_v, fl_rdy;
  logic      ax_block;
  logic      desc_valid, desc_ready;

  int n_checks = 0;
  int n_errors = 0;
  int aw_cnt   = 0;
  int ar_cnt   = 0;
  int fl_cnt   = 0;

  axi_llc_desc_merger #(
    .desc_t (llc_desc_t)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .aw_desc_i          (aw_desc),
    .aw_desc_valid_i    (aw_v),
    .aw_desc_ready_o    (aw_rdy),
    .ar_desc_i          (ar_desc),
    .ar_desc_valid_i    (ar_v),
    .ar_desc_ready_o    (ar_rdy),
    .aw_unit_busy_i     (aw_busy),
    .ar_unit_busy_i     (ar_busy),
    .flush_desc_i       (fl_desc),
    .flush_desc_valid_i (fl_v),
    .flush_desc_ready_o (fl_rdy),
    .ax_block_o         (ax_block),
    .desc_o             (desc_out),
    .desc_valid_o       (desc_valid),
    .desc_ready_i       (desc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aw_v;
    logic        ar_v;
    logic        rdy;
    logic        e_aw_rdy;
    logic        e_ar_rdy;
    logic        e_valid;
    logic [3:0]  e_id;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mkv(input logic a, input logic r, input logic d,
                               input logic ea, input logic er, input logic ev,
                               input logic [3:0] id, input logic [15:0] addr);
    vec_t v;
    v.aw_v = a; v.ar_v = r; v.rdy = d;
    v.e_aw_rdy = ea; v.e_ar_rdy = er; v.e_valid = ev;
    v.e_id = id; v.e_addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; each source moves to its next descriptor after a handshake.
  task automatic tick();
    logic aw_hs, ar_hs, fl_hs;
    aw_hs = aw_v && aw_rdy;
    ar_hs = ar_v && ar_rdy;
    fl_hs = fl_v && fl_rdy;
    @(posedge clk);
    #1;
    if (aw_hs) begin aw_cnt++; aw_desc.addr = 16'(aw_cnt); end
    if (ar_hs) begin ar_cnt++; ar_desc.addr = 16'(ar_cnt); end
    if (fl_hs) begin fl_cnt++; fl_desc.addr = 16'(fl_cnt); end
  endtask

  // Flush request arrives together with the first of n_aw AW or n_ar AR
  // descriptors (only one side non-zero). Expected output: AX first, then flush.
  task automatic flush_seq(input int n_aw, input int n_ar, input int n_fl);
    llc_desc_t exp_q[$];
    llc_desc_t got_q[$];
    llc_desc_t e;
    int  aw_left, ar_left, fl_left;
    bit  done, last_hs, first;
    aw_left = n_aw; ar_left = n_ar; fl_left = n_fl;
    done = 1'b0; last_hs = 1'b0; first = 1'b1;
    for (int i = 0; i < n_aw; i++) begin
      e.addr = 16'(aw_cnt + i); e.id = 4'd1; e.x_last = 1'b0; exp_q.push_back(e);
    end
    for (int i = 0; i < n_ar; i++) begin
      e.addr = 16'(ar_cnt + i); e.id = 4'd2; e.x_last = 1'b0; exp_q.push_back(e);
    end
    for (int i = 0; i < n_fl; i++) begin
      e.addr = 16'(fl_cnt + i); e.id = 4'd3; e.x_last = (i == n_fl - 1); exp_q.push_back(e);
    end
    desc_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      aw_v = (aw_left > 0); aw_busy = (aw_left > 0);
      ar_v = (ar_left > 0); ar_busy = (ar_left > 0);
      fl_v = (fl_left > 0); fl_desc.x_last = (fl_left == 1);
      #1;
      if (first) begin
        if (n_aw > 0) check("same_cycle_aw_grant", aw_rdy, 1'b1);
        else          check("same_cycle_ar_grant", ar_rdy, 1'b1);
        check("ax_block_first_cycle", ax_block, 1'b0);
        first = 1'b0;
      end else if (last_hs) begin
        check("ax_block_after_flush", ax_block, 1'b0);
        done = 1'b1;
      end else begin
        check("ax_block_during_flush", ax_block, 1'b1);
      end
      if (aw_left > 0 || ar_left > 0) check("flush_ready_while_ax", fl_rdy, 1'b0);
      if (desc_valid && desc_ready) got_q.push_back(desc_out);
      last_hs = fl_v && fl_rdy && fl_desc.x_last;
      if (aw_v && aw_rdy) aw_left--;
      if (ar_v && ar_rdy) ar_left--;
      if (fl_v && fl_rdy) fl_left--;
      tick();
    end
    if (!done) check("flush_seq_timeout", 32'd0, 32'd1);
    check("flush_seq_out_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("flush_seq_out[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1;
    aw_v = 1'b0; ar_v = 1'b0; fl_v = 1'b0;
    aw_busy = 1'b0; ar_busy = 1'b0; desc_ready = 1'b0;
    aw_desc = '{addr: 16'd0, id: 4'd1, x_last: 1'b0};
    ar_desc = '{addr: 16'd0, id: 4'd2, x_last: 1'b0};
    fl_desc = '{addr: 16'd0, id: 4'd3, x_last: 1'b0};

    // Reset state
    tick(); tick();
    check("rst_desc_valid", desc_valid, 1'b0);
    check("rst_ax_block",   ax_block,   1'b0);
    check("rst_flush_rdy",  fl_rdy,     1'b0);
    aw_v = 1'b1;
    #1;
    check("rst_aw_rdy_follows_grant", aw_rdy, 1'b1);
    aw_v = 1'b0;
    rst  = 1'b0;
    tick();

    // Arbitration and back-pressure vectors
    vecs[0]  = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
    vecs[1]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'd0);
    vecs[2]  = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'd0);
    vecs[3]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'd1);
    vecs[4]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 16'd1);
    vecs[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
    vecs[6]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 16'd2);
    vecs[7]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'd2);
    vecs[8]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd2);
    vecs[9]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'd3);
    vecs[10] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd4);
    vecs[11] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);

    for (int i = 0; i < 12; i++) begin
      aw_v = vecs[i].aw_v; ar_v = vecs[i].ar_v; desc_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_aw_rdy", i), aw_rdy, vecs[i].e_aw_rdy);
      check($sformatf("vec%0d_ar_rdy", i), ar_rdy, vecs[i].e_ar_rdy);
      check($sformatf("vec%0d_valid", i), desc_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_ax_block", i), ax_block, 1'b0);
      check($sformatf("vec%0d_fl_rdy", i), fl_rdy, 1'b0);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_id", i), desc_out.id, vecs[i].e_id);
        check($sformatf("vec%0d_addr", i), desc_out.addr, vecs[i].e_addr);
      end
      tick();
    end
    aw_v = 1'b0; ar_v = 1'b0;

    // Flush while AW is mid-burst with 4 descriptors left, 3 flush descriptors
    flush_seq(4, 0, 3);
    // Flush request in the same IDLE cycle as an AR descriptor
    flush_seq(0, 1, 1);

    // Reset while in FLUSH with two descriptors buffered
    desc_ready = 1'b0; fl_v = 1'b1; fl_desc.x_last = 1'b0;
    aw_v = 1'b0; ar_v = 1'b0; aw_busy = 1'b0; ar_busy = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("flush_full_valid",    desc_valid, 1'b1);
    check("flush_full_fl_rdy",   fl_rdy,     1'b0);
    check("flush_full_ax_block", ax_block,   1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; fl_v = 1'b0;
    #1;
    check("post_rst_valid",    desc_valid, 1'b0);
    check("post_rst_ax_block", ax_block,   1'b0);
    check("post_rst_fl_rdy",   fl_rdy,     1'b0);
    aw_v = 1'b1;
    #1;
    check("post_rst_idle_aw_rdy", aw_rdy, 1'b1);
    tick();
    aw_v = 1'b0;
    #1;
    check("post_rst_first_valid", desc_valid, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
